nec_ir_tx: RTL
==============

Name: nec_ir_tx

Overview:
- Parametrised NEC infrared remote-control transmitter driving the IrDA transceiver TXD pin.
- Accepts address/command words over a valid/ready handshake and serialises each as a complete NEC frame: leader, 32 data bits LSB-first, stop mark, and the mandatory inter-frame gap.
- Supports standard and extended-address NEC, NEC repeat frames, and configurable clock, carrier and output polarity.
- Replaces hard-coded single-code transmit logic at the top level.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- CARRIER_HZ, 38000, IR carrier frequency in Hz; half-period HALF = CLK_HZ/(2*CARRIER_HZ), floored (157 at defaults).
- EXTENDED, 0, 0 sends addr[7:0] followed by ~addr[7:0]; 1 sends addr[7:0] followed by addr[15:8].
- FRAME_UNITS, 192, minimum frame period in units, measured from leader start to next accept (108 ms).
- TXD_INV, 0, 1 inverts the txd pin level (idle becomes 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_valid  in  1  request to send a frame
- tx_ready  out  1  block can accept a request
- tx_repeat  in  1  sampled at accept: 1 sends a repeat frame; tx_addr and tx_cmd are ignored
- tx_addr  in  16  address; bits [15:8] used only when EXTENDED=1
- tx_cmd  in  8  command
- txd  out  1  modulated IR drive to the transceiver
- tx_active  out  1  unmodulated mark envelope, for debug
- busy  out  1  high from accept until tx_ready returns
- done  out  1  one-cycle pulse at the end of the stop mark

Behaviour:
- Timing:
  - UNIT = CLK_HZ*9/16000 clocks (562.5 us; 6750 at defaults).
  - All durations are integer multiples of UNIT; a single unit-tick counter plus a unit counter times every state.
- Reset (async): state IDLE, tx_ready=1, busy=0, done=0, tx_active=0, txd=TXD_INV, carrier counter=0, all counters cleared.
  - Reset asserted mid-frame aborts immediately, with no stop mark.
- Handshake:
  - Accept occurs on a cycle with tx_valid&&tx_ready.
  - On accept, latch tx_repeat, plus the data word {~cmd, cmd, b1, addr[7:0]}, where b1 = ~addr[7:0] if EXTENDED=0, else addr[15:8].
  - tx_ready drops the following cycle.
  - Input changes after accept have no effect.
- States (in order): IDLE -> LEAD_MARK(16 units) -> LEAD_SPACE -> ...
  - Normal frame: LEAD_SPACE lasts 8 units -> BIT_MARK(1) -> BIT_SPACE(1 if bit=0, 3 if bit=1) for bits 0..31 -> STOP_MARK(1) -> GAP.
  - Repeat frame: LEAD_SPACE lasts 4 units -> STOP_MARK(1) -> GAP.
  - GAP runs until FRAME_UNITS units have elapsed since LEAD_MARK start, then -> IDLE with tx_ready=1.
  - If the frame is already at least FRAME_UNITS long, GAP lasts one cycle.
- Latency: the first LEAD_MARK cycle (tx_active=1) is the cycle after accept.
- Envelope: tx_active=1 exactly in the *_MARK states, for exactly N*UNIT cycles each.
- Carrier:
  - The carrier counter restarts at 0 on every mark entry.
  - txd is high for HALF cycles, then low for HALF cycles, repeating (period 2*HALF).
  - txd=0 whenever tx_active=0.
  - All txd values are XORed with TXD_INV.
- Bit counter: 6-bit. The bit index advances at the end of BIT_SPACE; after bit 31, go to STOP_MARK.
- done: pulses on the last cycle of STOP_MARK.
- busy: equals ~tx_ready.
- Simultaneous events: tx_valid held continuously yields back-to-back frames spaced exactly FRAME_UNITS*UNIT+1 clocks from leader start to leader start.
- Elaboration: fail if HALF<1 or UNIT<1.

Test Plan:
- Reset check:
  - Assert rst_n=0 -> txd=0, tx_ready=1, busy=0.
  - Release, hold tx_valid=0 for 1 ms -> txd constant 0.
- Standard frame at defaults:
  - Stimulus: tx_addr=16'h0004, tx_cmd=8'h00.
  - Decoded envelope: 108000 cycles mark, 54000 space, then 32 bits LSB-first equal to 32'hFF00FB04, then a 6750-cycle stop mark.
  - Frame is 121 units; done pulses at cycle 121*6750 after accept; tx_ready returns at 192*6750.
- Carrier:
  - During any mark, txd toggles every 157 cycles, starting high on the first mark cycle.
  - txd=0 in all spaces.
  - With TXD_INV=1, all txd levels are inverted.
- Repeat and extended:
  - tx_repeat=1 -> 108000 mark, 27000 space, 6750 stop mark, no data bits.
  - EXTENDED=1 with addr=16'h1234, cmd=8'h56 -> decoded word 32'hA9561234.
- Back-to-back:
  - Hold tx_valid=1 with two different commands -> leader starts 1296001 cycles apart.
  - Second frame carries the second command; tx_addr/tx_cmd changes after accept do not alter the first frame.
- Mid-frame reset:
  - Pulse rst_n low during bit 10 mark -> txd=0 within the reset cycle (async).
  - After release, tx_ready=1 and a new frame transmits correctly.

Source files
------------

// File: rtl/nec_ir_tx.sv
// NEC infrared remote-control transmitter.
// Accepts address/command words over a valid/ready handshake and sends each
// one as a complete NEC frame. A frame is a leader, 32 data bits LSB-first
// and a stop mark, followed by a gap that pads the frame to FRAME_UNITS
// units. Marks are modulated with the carrier on txd.
// Ports:
//   clk, rst_n             - system clock, async active-low reset
//   tx_valid / tx_ready    - request handshake
//   tx_repeat              - sampled at accept, sends a repeat frame
//   tx_addr, tx_cmd        - address (high byte used when EXTENDED=1), command
//   txd                    - modulated IR drive (XOR TXD_INV)
//   tx_active              - unmodulated mark envelope
//   busy                   - ~tx_ready
//   done                   - pulse on the last cycle of the stop mark
module nec_ir_tx #(
    parameter int unsigned CLK_HZ      = 12000000,
    parameter int unsigned CARRIER_HZ  = 38000,
    parameter bit          EXTENDED    = 1'b0,
    parameter int unsigned FRAME_UNITS = 192,
    parameter bit          TXD_INV     = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        tx_repeat,
    input  logic [15:0] tx_addr,
    input  logic [7:0]  tx_cmd,
    output logic        txd,
    output logic        tx_active,
    output logic        busy,
    output logic        done
);

    localparam int unsigned HALF = CLK_HZ / (2 * CARRIER_HZ);
    localparam int unsigned UNIT = 32'(64'(CLK_HZ) * 64'd9 / 64'd16000);
    localparam int unsigned TW   = $clog2(UNIT + 1);
    localparam int unsigned CW   = $clog2(2 * HALF + 1);
    localparam int unsigned FW   = $clog2(FRAME_UNITS + 256);
    localparam int unsigned UW   = 5;

    if (HALF < 1) begin : g_chk_half
        $error("nec_ir_tx: carrier half-period must be at least one clock");
    end
    if (UNIT < 1) begin : g_chk_unit
        $error("nec_ir_tx: NEC unit must be at least one clock");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [UW-1:0]   unit_q, unit_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [5:0]      bit_q, bit_d;
    logic [CW-1:0]   carr_q, carr_d;
    logic [31:0]     data_q, data_d;
    logic            rpt_q, rpt_d;
    logic            tx_ready_q, tx_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tx_active_q, tx_active_d;
    logic            txd_q, txd_d;
    logic            accept;
    logic            unit_end;
    logic            state_end;
    logic            mark_d;
    logic [UW-1:0]   dur;

    assign accept    = tx_valid && tx_ready_q;
    assign tx_ready  = tx_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tx_active = tx_active_q;
    assign txd       = txd_q;

    // State and datapath registers; outputs are registered from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            unit_q      <= '0;
            frame_q     <= '0;
            bit_q       <= '0;
            carr_q      <= '0;
            data_q      <= '0;
            rpt_q       <= 1'b0;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_active_q <= 1'b0;
            txd_q       <= TXD_INV;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            unit_q      <= unit_d;
            frame_q     <= frame_d;
            bit_q       <= bit_d;
            carr_q      <= carr_d;
            data_q      <= data_d;
            rpt_q       <= rpt_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tx_active_q <= tx_active_d;
            txd_q       <= txd_d;
        end
    end

    // Next state, unit timing, bit sequencing and carrier phase.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        unit_d  = unit_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        data_d  = data_q;
        rpt_d   = rpt_q;
        carr_d  = carr_q;

        unit_end = (tick_q == TW'(UNIT - 1));

        // Length of the current state in units.
        case (state_q)
            S_LEAD_MARK:  dur = UW'(16);
            S_LEAD_SPACE: dur = rpt_q ? UW'(4) : UW'(8);
            S_BIT_SPACE:  dur = data_q[bit_q[4:0]] ? UW'(3) : UW'(1);
            default:      dur = UW'(1);
        endcase
        state_end = unit_end && (unit_q == dur - UW'(1));

        // Frame counter keeps running across states to time the gap.
        if (state_q != S_IDLE) begin
            tick_d = unit_end ? '0 : tick_q + TW'(1);
            if (unit_end) begin
                unit_d  = unit_q + UW'(1);
                frame_d = frame_q + FW'(1);
            end
            if (state_end) begin
                unit_d = '0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LEAD_MARK;
                    tick_d  = '0;
                    unit_d  = '0;
                    frame_d = '0;
                    bit_d   = '0;
                    rpt_d   = tx_repeat;
                    data_d  = {~tx_cmd, tx_cmd,
                               EXTENDED ? tx_addr[15:8] : ~tx_addr[7:0],
                               tx_addr[7:0]};
                end
            end
            S_LEAD_MARK: begin
                if (state_end) state_d = S_LEAD_SPACE;
            end
            S_LEAD_SPACE: begin
                if (state_end) state_d = rpt_q ? S_STOP_MARK : S_BIT_MARK;
            end
            S_BIT_MARK: begin
                if (state_end) state_d = S_BIT_SPACE;
            end
            S_BIT_SPACE: begin
                if (state_end) begin
                    bit_d   = bit_q + 6'd1;
                    state_d = (bit_q == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
                end
            end
            S_STOP_MARK: begin
                if (state_end) state_d = S_GAP;
            end
            S_GAP: begin
                // Leaves immediately when the frame already filled the period.
                if ((frame_q >= FW'(FRAME_UNITS)) ||
                    (unit_end && (frame_q + FW'(1) >= FW'(FRAME_UNITS)))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mark_d = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) ||
                 (state_d == S_STOP_MARK);

        // Carrier phase restarts on every mark entry so each mark starts high.
        if (!mark_d || (state_d != state_q)) begin
            carr_d = '0;
        end else if (carr_q == CW'(2 * HALF - 1)) begin
            carr_d = '0;
        end else begin
            carr_d = carr_q + CW'(1);
        end
    end

    // Output decode from next-state values so registered outputs align with state.
    always_comb begin
        tx_ready_d  = (state_d == S_IDLE);
        busy_d      = ~tx_ready_d;
        tx_active_d = mark_d;
        txd_d       = (mark_d && (carr_d < CW'(HALF))) ^ TXD_INV;
        done_d      = (state_d == S_STOP_MARK) && (tick_d == TW'(UNIT - 1));
    end

endmodule
